// File: rtl/pic_banked_regfile.sv
// PIC16C5x-class file register block: banked GPR, FSR/STATUS/OPTION/TRIS, port latches and
// TMR0 with an 8-bit prescaler and a synchronised external clock input.
module pic_banked_regfile #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PC_WIDTH   = 9,
  parameter int unsigned IO_A_WIDTH = 4,
  parameter int unsigned IO_B_WIDTH = 8,
  parameter int unsigned IO_C_WIDTH = 8,
  parameter int unsigned NUM_BANKS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            writeCommand,
  input  logic [4:0]            fileAddr,
  input  logic [DATA_WIDTH-1:0] writeDataIn,
  input  logic [DATA_WIDTH-1:0] statusIn,
  input  logic [IO_A_WIDTH-1:0] portAIn,
  input  logic [IO_B_WIDTH-1:0] portBIn,
  input  logic [IO_C_WIDTH-1:0] portCIn,
  input  logic                  t0cki,
  input  logic [PC_WIDTH-1:0]   pcIn,
  output logic [DATA_WIDTH-1:0] fsrOut,
  output logic [DATA_WIDTH-1:0] regfileOut,
  output logic [DATA_WIDTH-1:0] statusOut,
  output logic [5:0]            optionOut,
  output logic [DATA_WIDTH-1:0] tmr0Out,
  output logic                  tmr0Overflow,
  output logic                  pclWe,
  output logic [IO_A_WIDTH-1:0] portAOut,
  output logic [IO_B_WIDTH-1:0] portBOut,
  output logic [IO_C_WIDTH-1:0] portCOut,
  output logic [IO_A_WIDTH-1:0] trisAOut,
  output logic [IO_B_WIDTH-1:0] trisBOut,
  output logic [IO_C_WIDTH-1:0] trisCOut
);

  localparam int unsigned BankBits = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int unsigned GprDepth = 8 + 16 * NUM_BANKS;
  // FSR bits above the address and bank fields are unimplemented and read as 1.
  localparam logic [DATA_WIDTH-1:0] FsrOnes = {DATA_WIDTH{1'b1}} << (5 + BankBits);

  typedef enum logic [2:0] {
    CmdNone      = 3'b000,
    CmdStatus    = 3'b001,
    CmdFile      = 3'b010,
    CmdFileFlags = 3'b011,
    CmdOption    = 3'b100,
    CmdTris      = 3'b101
  } cmd_e;

  logic [DATA_WIDTH-1:0] status_q, status_d;
  logic [DATA_WIDTH-1:0] fsr_q, fsr_d;
  logic [5:0]            option_q, option_d;
  logic [DATA_WIDTH-1:0] tmr0_q, tmr0_d;
  logic [7:0]            presc_q, presc_d;
  logic [1:0]            inhibit_q, inhibit_d;
  logic                  ovf_q, ovf_d;
  logic [2:0]            sync_q, sync_d;
  logic [IO_A_WIDTH-1:0] port_a_q, port_a_d, tris_a_q, tris_a_d;
  logic [IO_B_WIDTH-1:0] port_b_q, port_b_d, tris_b_q, tris_b_d;
  logic [IO_C_WIDTH-1:0] port_c_q, port_c_d, tris_c_q, tris_c_d;
  logic [DATA_WIDTH-1:0] gpr_q [GprDepth];

  logic [4:0]            ea;
  logic [2:0]            bank;
  logic [6:0]            gpr_idx;
  logic                  file_wr;
  logic                  gpr_we;
  logic                  tmr0_wr;
  logic [DATA_WIDTH-1:0] pin_a, pin_b, pin_c;
  logic                  t0_edge;
  logic                  src_tick;
  logic                  tick;
  logic                  tmr0_inc;
  logic [7:0]            ps_mask;

  if (PC_WIDTH > 8) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^pcIn[PC_WIDTH-1:8];
  end

  // Address decode and GPR indexing: 0x08-0x0F are common, 0x10-0x1F are per bank.
  always_comb begin
    ea      = (fileAddr == 5'h00) ? fsr_q[4:0] : fileAddr;
    bank    = fsr_q[7:5] & 3'(NUM_BANKS - 1);
    file_wr = (writeCommand == CmdFile) || (writeCommand == CmdFileFlags);
    tmr0_wr = file_wr && (ea == 5'h01);
    gpr_we  = file_wr && (ea >= 5'h08);
    if (ea[4]) begin
      gpr_idx = 7'd8 + {bank, ea[3:0]};
    end else begin
      gpr_idx = {4'b0000, ea[2:0]};
    end
  end

  always_comb begin
    pin_a = '0;
    pin_b = '0;
    pin_c = '0;
    pin_a[IO_A_WIDTH-1:0] = portAIn;
    pin_b[IO_B_WIDTH-1:0] = portBIn;
    pin_c[IO_C_WIDTH-1:0] = portCIn;
  end

  always_comb begin
    regfileOut = '0;
    case (ea)
      5'h00:   regfileOut = '0;
      5'h01:   regfileOut = tmr0_q;
      5'h02:   regfileOut = DATA_WIDTH'(pcIn[7:0]);
      5'h03:   regfileOut = status_q;
      5'h04:   regfileOut = fsr_q | FsrOnes;
      5'h05:   regfileOut = pin_a;
      5'h06:   regfileOut = pin_b;
      5'h07:   regfileOut = pin_c;
      default: regfileOut = gpr_q[gpr_idx];
    endcase
  end

  assign pclWe = file_wr && (ea == 5'h02);

  // STATUS: TO/PD are only writable through the full 001 load; ALU flags win over data on 011.
  always_comb begin
    status_d = status_q;
    case (writeCommand)
      CmdStatus: status_d = statusIn;
      CmdFile: begin
        if (ea == 5'h03) status_d = {writeDataIn[7:5], status_q[4:3], writeDataIn[2:0]};
      end
      CmdFileFlags: begin
        if (ea == 5'h03) begin
          status_d = {writeDataIn[7:5], status_q[4:3], statusIn[2:0]};
        end else begin
          status_d = {status_q[7:5], statusIn[4:0]};
        end
      end
      default: status_d = status_q;
    endcase
  end

  always_comb begin
    fsr_d    = fsr_q;
    option_d = option_q;
    port_a_d = port_a_q;
    port_b_d = port_b_q;
    port_c_d = port_c_q;
    tris_a_d = tris_a_q;
    tris_b_d = tris_b_q;
    tris_c_d = tris_c_q;
    if (file_wr) begin
      case (ea)
        5'h04:   fsr_d = writeDataIn | FsrOnes;
        5'h05:   port_a_d = writeDataIn[IO_A_WIDTH-1:0];
        5'h06:   port_b_d = writeDataIn[IO_B_WIDTH-1:0];
        5'h07:   port_c_d = writeDataIn[IO_C_WIDTH-1:0];
        default: fsr_d = fsr_q;
      endcase
    end
    if (writeCommand == CmdOption) option_d = writeDataIn[5:0];
    if (writeCommand == CmdTris) begin
      case (fileAddr)
        5'h05:   tris_a_d = writeDataIn[IO_A_WIDTH-1:0];
        5'h06:   tris_b_d = writeDataIn[IO_B_WIDTH-1:0];
        5'h07:   tris_c_d = writeDataIn[IO_C_WIDTH-1:0];
        default: tris_a_d = tris_a_q;
      endcase
    end
  end

  // TMR0 clock source, prescaler and write inhibit. Mode changes apply from the next cycle.
  always_comb begin
    sync_d    = {sync_q[1:0], t0cki};
    t0_edge   = option_q[4] ? (~sync_q[1] & sync_q[2]) : (sync_q[1] & ~sync_q[2]);
    src_tick  = option_q[5] ? t0_edge : 1'b1;
    tick      = src_tick && (inhibit_q == 2'd0);
    ps_mask   = 8'((9'd2 << option_q[2:0]) - 9'd1);
    tmr0_inc  = 1'b0;
    presc_d   = presc_q;
    if (option_q[3]) begin
      presc_d  = '0;
      tmr0_inc = tick;
    end else if (tick) begin
      presc_d  = presc_q + 8'd1;
      tmr0_inc = ((presc_q & ps_mask) == ps_mask);
    end
    tmr0_d    = tmr0_q;
    ovf_d     = 1'b0;
    inhibit_d = (inhibit_q != 2'd0) ? inhibit_q - 2'd1 : 2'd0;
    if (tmr0_wr) begin
      tmr0_d    = writeDataIn;
      presc_d   = '0;
      inhibit_d = 2'd2;
    end else if (tmr0_inc) begin
      tmr0_d = tmr0_q + 1'b1;
      ovf_d  = (tmr0_q == '1);
    end
    if (writeCommand == CmdOption) presc_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q  <= DATA_WIDTH'(8'h18);
      fsr_q     <= FsrOnes;
      option_q  <= 6'h3F;
      tmr0_q    <= '0;
      presc_q   <= '0;
      inhibit_q <= '0;
      ovf_q     <= 1'b0;
      sync_q    <= '0;
      port_a_q  <= '0;
      port_b_q  <= '0;
      port_c_q  <= '0;
      tris_a_q  <= '1;
      tris_b_q  <= '1;
      tris_c_q  <= '1;
    end else begin
      status_q  <= status_d;
      fsr_q     <= fsr_d;
      option_q  <= option_d;
      tmr0_q    <= tmr0_d;
      presc_q   <= presc_d;
      inhibit_q <= inhibit_d;
      ovf_q     <= ovf_d;
      sync_q    <= sync_d;
      port_a_q  <= port_a_d;
      port_b_q  <= port_b_d;
      port_c_q  <= port_c_d;
      tris_a_q  <= tris_a_d;
      tris_b_q  <= tris_b_d;
      tris_c_q  <= tris_c_d;
    end
  end

  // GPR contents survive reset.
  always_ff @(posedge clk) begin
    if (gpr_we) gpr_q[gpr_idx] <= writeDataIn;
  end

  assign fsrOut       = fsr_q | FsrOnes;
  assign statusOut    = status_q;
  assign optionOut    = option_q;
  assign tmr0Out      = tmr0_q;
  assign tmr0Overflow = ovf_q;
  assign portAOut     = port_a_q;
  assign portBOut     = port_b_q;
  assign portCOut     = port_c_q;
  assign trisAOut     = tris_a_q;
  assign trisBOut     = tris_b_q;
  assign trisCOut     = tris_c_q;

endmodule

// File: tb/tb_pic_banked_regfile.sv
// Directed and randomized checks of pic_banked_regfile against a behavioural model
// of the register file, STATUS rules and TMR0 timing.
module tb_pic_banked_regfile;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] writeCommand = '0;
  logic [4:0] fileAddr = '0;
  logic [7:0] writeDataIn = '0, statusIn = '0;
  logic [3:0] portAIn = '0;
  logic [7:0] portBIn = '0, portCIn = '0;
  logic       t0cki = 1'b0;
  logic [8:0] pcIn = '0;
  logic [7:0] fsrOut, regfileOut, statusOut, tmr0Out;
  logic [5:0] optionOut;
  logic       tmr0Overflow, pclWe;
  logic [3:0] portAOut, trisAOut;
  logic [7:0] portBOut, portCOut, trisBOut, trisCOut;

  pic_banked_regfile #(
    .DATA_WIDTH(8), .PC_WIDTH(9), .IO_A_WIDTH(4), .IO_B_WIDTH(8), .IO_C_WIDTH(8),
    .NUM_BANKS(NB)
  ) dut (
    .clk(clk), .rst(rst), .writeCommand(writeCommand), .fileAddr(fileAddr),
    .writeDataIn(writeDataIn), .statusIn(statusIn), .portAIn(portAIn), .portBIn(portBIn),
    .portCIn(portCIn), .t0cki(t0cki), .pcIn(pcIn), .fsrOut(fsrOut), .regfileOut(regfileOut),
    .statusOut(statusOut), .optionOut(optionOut), .tmr0Out(tmr0Out),
    .tmr0Overflow(tmr0Overflow), .pclWe(pclWe), .portAOut(portAOut), .portBOut(portBOut),
    .portCOut(portCOut), .trisAOut(trisAOut), .trisBOut(trisBOut), .trisCOut(trisCOut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [7:0] m_status, m_fsr, m_tmr0, m_pb, m_pc, m_tb, m_tc;
  logic [3:0] m_pa, m_ta;
  logic [5:0] m_option;
  int         m_presc;
  int         m_inh;
  bit         m_ovf;
  bit         hist[$];
  logic [7:0] m_gpr [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_status = 8'h18; m_fsr = 8'h80; m_option = 6'h3F; m_tmr0 = 8'h00;
    m_presc = 0; m_inh = 0; m_ovf = 1'b0;
    m_pa = '0; m_pb = '0; m_pc = '0; m_ta = '1; m_tb = '1; m_tc = '1;
    hist = '{1'b0, 1'b0, 1'b0};
  endtask

  function automatic logic [4:0] ea_of();
    return (fileAddr == 5'h00) ? m_fsr[4:0] : fileAddr;
  endfunction

  function automatic int key_of(input logic [4:0] ea);
    if (ea < 5'h10) return int'(ea);
    return int'(ea) + 32 * ((int'(m_fsr) >> 5) % NB);
  endfunction

  task automatic check_comb();
    logic [4:0] ea;
    logic [7:0] exp;
    bit         known;
    ea = ea_of();
    known = 1'b1;
    case (ea)
      5'h00:   exp = 8'h00;
      5'h01:   exp = m_tmr0;
      5'h02:   exp = pcIn[7:0];
      5'h03:   exp = m_status;
      5'h04:   exp = m_fsr;
      5'h05:   exp = {4'h0, portAIn};
      5'h06:   exp = portBIn;
      5'h07:   exp = portCIn;
      default: begin
        known = m_gpr.exists(key_of(ea));
        exp = known ? m_gpr[key_of(ea)] : 8'h00;
      end
    endcase
    if (known) check("regfileOut", regfileOut, exp);
    check("pclWe", pclWe, (writeCommand inside {3'd2, 3'd3}) && ea == 5'h02);
  endtask

  task automatic check_regs();
    check("statusOut", statusOut, m_status);
    check("fsrOut", fsrOut, m_fsr);
    check("optionOut", optionOut, m_option);
    check("tmr0Out", tmr0Out, m_tmr0);
    check("tmr0Overflow", tmr0Overflow, m_ovf);
    check("portAOut", portAOut, m_pa);
    check("portBOut", portBOut, m_pb);
    check("portCOut", portCOut, m_pc);
    check("trisAOut", trisAOut, m_ta);
    check("trisBOut", trisBOut, m_tb);
    check("trisCOut", trisCOut, m_tc);
  endtask

  // One rising edge of the reference model, using the inputs currently driven.
  task automatic model_clock();
    logic [4:0] ea;
    bit         fw, s1, s2, src, tick, inc;
    int         n_presc, n_inh, ps_div;
    ea = ea_of();
    fw = writeCommand inside {3'd2, 3'd3};
    s1 = hist[$-1];
    s2 = hist[$-2];
    src = m_option[5] ? (m_option[4] ? (!s1 && s2) : (s1 && !s2)) : 1'b1;
    tick = src && (m_inh == 0);
    n_presc = m_presc;
    n_inh = m_inh;
    m_ovf = 1'b0;
    if (fw && ea == 5'h01) begin
      m_tmr0 = writeDataIn;
      n_presc = 0;
      n_inh = 2;
    end else begin
      inc = 1'b0;
      if (tick) begin
        if (m_option[3]) begin
          inc = 1'b1;
        end else begin
          ps_div = 2 << m_option[2:0];
          n_presc = m_presc + 1;
          inc = (n_presc % ps_div) == 0;
        end
      end
      if (inc) begin
        m_ovf = (m_tmr0 == 8'hFF);
        m_tmr0 = m_tmr0 + 8'd1;
      end
      if (m_inh > 0) n_inh = m_inh - 1;
    end
    if (writeCommand == 3'd4) begin
      n_presc = 0;
      m_option = writeDataIn[5:0];
    end
    m_presc = n_presc;
    m_inh = n_inh;
    if (writeCommand == 3'd1) m_status = statusIn;
    else if (writeCommand == 3'd2 && ea == 5'h03)
      m_status = {writeDataIn[7:5], m_status[4:3], writeDataIn[2:0]};
    else if (writeCommand == 3'd3 && ea == 5'h03)
      m_status = {writeDataIn[7:5], m_status[4:3], statusIn[2:0]};
    else if (writeCommand == 3'd3)
      m_status = {m_status[7:5], statusIn[4:0]};
    if (fw && ea >= 5'h08) m_gpr[key_of(ea)] = writeDataIn;
    if (fw && ea == 5'h05) m_pa = writeDataIn[3:0];
    if (fw && ea == 5'h06) m_pb = writeDataIn;
    if (fw && ea == 5'h07) m_pc = writeDataIn;
    if (fw && ea == 5'h04) m_fsr = writeDataIn | 8'h80;
    if (writeCommand == 3'd5 && fileAddr == 5'h05) m_ta = writeDataIn[3:0];
    if (writeCommand == 3'd5 && fileAddr == 5'h06) m_tb = writeDataIn;
    if (writeCommand == 3'd5 && fileAddr == 5'h07) m_tc = writeDataIn;
    hist.push_back(t0cki);
    if (hist.size() > 3) void'(hist.pop_front());
  endtask

  task automatic step(input logic [2:0] c, input logic [4:0] fa, input logic [7:0] wd,
                      input logic [7:0] st, input logic t0);
    writeCommand = c; fileAddr = fa; writeDataIn = wd; statusIn = st; t0cki = t0;
    pcIn = 9'($urandom); portAIn = 4'($urandom); portBIn = 8'($urandom);
    portCIn = 8'($urandom);
    @(negedge clk);
    check_comb();
    @(posedge clk);
    model_clock();
    #1;
    check_regs();
  endtask

  task automatic rd_lit(input string tag, input logic [4:0] fa, input logic [7:0] exp);
    writeCommand = 3'd0;
    fileAddr = fa;
    #1;
    check(tag, regfileOut, exp);
  endtask

  int ovf_cnt;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    check("rst_status", statusOut, 8'h18);
    check("rst_fsr", fsrOut, 8'h80);
    check("rst_option", optionOut, 6'h3F);
    check("rst_trisA", trisAOut, 4'hF);
    rst = 1'b1;

    // Banked GPR through INDF, common area shared by all banks
    step(3'd2, 5'h04, 8'h90, 8'h00, 1'b0);
    step(3'd2, 5'h00, 8'hA5, 8'h00, 1'b0);
    step(3'd2, 5'h04, 8'hB0, 8'h00, 1'b0);
    step(3'd2, 5'h00, 8'h5A, 8'h00, 1'b0);
    step(3'd2, 5'h04, 8'h90, 8'h00, 1'b0);
    rd_lit("bank0_indf", 5'h00, 8'hA5);
    step(3'd2, 5'h04, 8'hB0, 8'h00, 1'b0);
    rd_lit("bank1_indf", 5'h00, 8'h5A);
    step(3'd2, 5'h0A, 8'h77, 8'h00, 1'b0);
    step(3'd2, 5'h04, 8'h0A, 8'h00, 1'b0);
    check("fsr_unused_ones", fsrOut, 8'h8A);
    rd_lit("common_b0", 5'h00, 8'h77);
    step(3'd2, 5'h04, 8'hAA, 8'h00, 1'b0);
    rd_lit("common_b1", 5'h00, 8'h77);

    // STATUS write with flags
    step(3'd3, 5'h03, 8'hE0, 8'h04, 1'b0);
    check("status_flags", statusOut, 8'hFC);

    // Internal clock, 1:2 prescale, wrap and overflow pulse
    step(3'd4, 5'h00, 8'h00, 8'h00, 1'b0);
    step(3'd2, 5'h01, 8'hFE, 8'h00, 1'b0);
    ovf_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(3'd0, 5'h08, 8'h00, 8'h00, 1'b0);
      if (tmr0Overflow) ovf_cnt++;
      if (i == 5) begin
        check("tmr0_wrap", tmr0Out, 8'h00);
        check("tmr0_ovf_pulse", tmr0Overflow, 1'b1);
      end
    end
    check("ovf_pulse_count", ovf_cnt, 1);

    // External clock, rising edge, no prescale
    step(3'd4, 5'h00, 8'h28, 8'h00, 1'b0);
    step(3'd2, 5'h01, 8'h00, 8'h00, 1'b0);
    repeat (3) step(3'd0, 5'h08, 8'h00, 8'h00, 1'b0);
    for (int p = 0; p < 5; p++) begin
      repeat (2) step(3'd0, 5'h08, 8'h00, 8'h00, 1'b1);
      repeat (2) step(3'd0, 5'h08, 8'h00, 8'h00, 1'b0);
    end
    repeat (4) step(3'd0, 5'h08, 8'h00, 8'h00, 1'b0);
    check("t0cki_count", tmr0Out, 8'h05);
    step(3'd2, 5'h01, 8'h00, 8'h00, 1'b1);
    repeat (3) step(3'd0, 5'h08, 8'h00, 8'h00, 1'b1);
    repeat (4) step(3'd0, 5'h08, 8'h00, 8'h00, 1'b0);
    check("t0cki_inhibit", tmr0Out, 8'h00);

    // TRIS, port latch, pin read, PCL strobe
    step(3'd5, 5'h06, 8'h0F, 8'h00, 1'b0);
    check("trisB", trisBOut, 8'h0F);
    step(3'd2, 5'h06, 8'hC3, 8'h00, 1'b0);
    check("portB_latch", portBOut, 8'hC3);
    portBIn = 8'h3C;
    rd_lit("portB_pins", 5'h06, 8'h3C);
    writeCommand = 3'd2;
    fileAddr = 5'h02;
    #1;
    check("pclwe_hi", pclWe, 1'b1);
    step(3'd2, 5'h02, 8'h40, 8'h00, 1'b0);
    writeCommand = 3'd0;
    #1;
    check("pclwe_lo", pclWe, 1'b0);

    // Asynchronous reset mid-count
    step(3'd4, 5'h00, 8'h01, 8'h00, 1'b0);
    step(3'd2, 5'h01, 8'h37, 8'h00, 1'b0);
    repeat (3) step(3'd0, 5'h08, 8'h00, 8'h00, 1'b0);
    check("tmr0_pre_reset", tmr0Out, 8'h37);
    rst = 1'b0;
    #1;
    check("arst_tmr0", tmr0Out, 8'h00);
    check("arst_option", optionOut, 6'h3F);
    check("arst_status", statusOut, 8'h18);
    check("arst_fsr", fsrOut, 8'h80);
    check("arst_portB", portBOut, 8'h00);
    check("arst_trisB", trisBOut, 8'hFF);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    check_regs();
    rd_lit("gpr_kept_common", 5'h0A, 8'h77);
    rd_lit("gpr_kept_bank0", 5'h10, 8'hA5);

    // Randomized traffic against the model
    repeat (400) begin
      step(3'($urandom_range(0, 7)), 5'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
